// File: rtl/chroma_subsampler.sv
// Wishbone-classic chroma subsampler: gathers 1/2/4 YCrCb pixels and emits
// the averaged Cr/Cb pair together with the group's Y samples.
module chroma_subsampler #(
    parameter int CW        = 8,
    parameter int DEF_MODE  = 2,
    parameter int DEF_ROUND = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic [31:0] ADR_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    input  logic [3:0]  SEL_I,
    output logic        ACK_O
);

    typedef enum logic {ST_FILL = 1'b0, ST_SUM = 1'b1} state_t;

    localparam logic [1:0]    DEF_MODE_L  = (DEF_MODE >= 2) ? 2'd2 : 2'(DEF_MODE);
    localparam logic          DEF_ROUND_L = (DEF_ROUND != 0);
    localparam logic [CW+1:0] SAT         = {2'b00, {CW{1'b1}}};

    state_t          state;
    logic [1:0]      mode;
    logic            rnd;
    logic [2:0]      fill;
    logic [CW+1:0]   sum_cr, sum_cb;
    logic [CW-1:0]   y_reg [4];
    logic [CW-1:0]   yout  [4];
    logic [CW-1:0]   cro, cbo;
    logic            out_valid, overflow;

    logic            acc, rd_acc, wr_acc, ctrl_wr, stat_wr, pix_wr;
    logic            busy, held, completes;
    logic [3:0]      reg_idx;
    logic [2:0]      grp_n;
    logic [1:0]      grp_l;
    logic [CW+1:0]   rnd_add, cr_avg, cb_avg;
    logic [CW-1:0]   cr_q, cb_q, y_in, cr_in, cb_in;
    logic [31:0]     rd_data;
    logic            unused_bits;

    assign unused_bits = ^{ADR_I[31:6], ADR_I[1:0], DAT_I};

    assign acc     = CYC_I & STB_I & ~ACK_O;
    assign reg_idx = ADR_I[5:2];
    assign rd_acc  = acc & ~WE_I;
    assign wr_acc  = acc & WE_I;
    assign ctrl_wr = wr_acc && (reg_idx == 4'd0) && SEL_I[0];
    assign stat_wr = wr_acc && (reg_idx == 4'd2) && SEL_I[0];
    assign pix_wr  = wr_acc && (reg_idx == 4'd1) && (SEL_I == 4'hF);

    assign y_in  = DAT_I[CW-1:0];
    assign cr_in = DAT_I[2*CW-1:CW];
    assign cb_in = DAT_I[3*CW-1:2*CW];

    assign busy      = (fill != 3'd0) || (state == ST_SUM);
    // A full group waiting for its SUM cycle cannot accept further pixels.
    assign held      = (state == ST_SUM) || (fill == grp_n);
    assign completes = ((fill + 3'd1) == grp_n);

    always_comb begin
        case (mode)
            2'd0:    begin grp_n = 3'd1; grp_l = 2'd0; end
            2'd1:    begin grp_n = 3'd2; grp_l = 2'd1; end
            default: begin grp_n = 3'd4; grp_l = 2'd2; end
        endcase
    end

    always_comb begin
        rnd_add = rnd ? (CW+2)'(grp_n >> 1) : '0;
        cr_avg  = (sum_cr + rnd_add) >> grp_l;
        cb_avg  = (sum_cb + rnd_add) >> grp_l;
        cr_q    = (cr_avg > SAT) ? '1 : cr_avg[CW-1:0];
        cb_q    = (cb_avg > SAT) ? '1 : cb_avg[CW-1:0];
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            4'd0:                    rd_data[2:0]    = {rnd, mode};
            4'd2:                    rd_data[5:0]    = {fill, overflow, out_valid, busy};
            4'd4, 4'd5, 4'd6, 4'd7:  rd_data[CW-1:0] = yout[reg_idx[1:0]];
            4'd8:                    rd_data[CW-1:0] = cro;
            4'd9:                    rd_data[CW-1:0] = cbo;
            default:                 rd_data         = '0;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ACK_O     <= 1'b0;
            DAT_O     <= '0;
            state     <= ST_FILL;
            mode      <= DEF_MODE_L;
            rnd       <= DEF_ROUND_L;
            fill      <= '0;
            sum_cr    <= '0;
            sum_cb    <= '0;
            cro       <= '0;
            cbo       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                y_reg[i] <= '0;
                yout[i]  <= '0;
            end
        end else begin
            ACK_O <= acc;
            if (rd_acc)
                DAT_O <= rd_data;
            if (rd_acc && (reg_idx == 4'd9))
                out_valid <= 1'b0;

            // SUM publishes after a CBOUT read in the same cycle, so out_valid ends set.
            if ((state == ST_SUM) && !ctrl_wr) begin
                cro <= cr_q;
                cbo <= cb_q;
                for (int unsigned i = 0; i < 4; i++)
                    yout[i] <= (3'(i) < grp_n) ? y_reg[i] : '0;
                out_valid <= 1'b1;
                sum_cr    <= '0;
                sum_cb    <= '0;
                fill      <= '0;
                state     <= ST_FILL;
            end else if ((state == ST_FILL) && (fill == grp_n)) begin
                state <= ST_SUM;
            end

            if (pix_wr) begin
                if (held || (completes && out_valid)) begin
                    overflow <= 1'b1;
                end else begin
                    y_reg[fill[1:0]] <= y_in;
                    sum_cr <= sum_cr + {2'b00, cr_in};
                    sum_cb <= sum_cb + {2'b00, cb_in};
                    fill   <= fill + 3'd1;
                end
            end

            if (stat_wr && DAT_I[2])
                overflow <= 1'b0;

            if (ctrl_wr) begin
                mode      <= (DAT_I[1:0] == 2'd3) ? 2'd2 : DAT_I[1:0];
                rnd       <= DAT_I[2];
                fill      <= '0;
                sum_cr    <= '0;
                sum_cb    <= '0;
                out_valid <= 1'b0;
                state     <= ST_FILL;
            end
        end
    end

endmodule

// File: tb/tb_chroma_subsampler.sv
// Table-driven bench for chroma_subsampler over its Wishbone register map.
module tb_chroma_subsampler;

    logic        clk = 1'b0;
    logic        RST_I;
    logic [31:0] DAT_I, DAT_O, ADR_I;
    logic        WE_I, STB_I, CYC_I, ACK_O;
    logic [3:0]  SEL_I;

    int checks = 0;
    int errors = 0;

    chroma_subsampler #(.CW(8), .DEF_MODE(2), .DEF_ROUND(1)) dut (
        .CLK_I(clk), .RST_I(RST_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
        .ADR_I(ADR_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
        .SEL_I(SEL_I), .ACK_O(ACK_O)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void W(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s = 4'hF);
        tbl.push_back('{we: 1'b1, idx: idx, data: d, sel: s, exp: 32'h0});
    endfunction

    function automatic void R(input logic [3:0] idx, input logic [31:0] e);
        tbl.push_back('{we: 1'b0, idx: idx, data: 32'h0, sel: 4'h0, exp: e});
    endfunction

    // Group A: Cr=10,20,30,42  Cb=100,100,100,101  Y=1..4
    function automatic void group_a();
        W(1, 32'h640A01); W(1, 32'h641402); W(1, 32'h641E03); W(1, 32'h652A04);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [3:0] idx, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd);
        int unsigned n;
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we;
        ADR_I = {26'd0, idx, 2'b00}; DAT_I = d; SEL_I = sel;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ACK_O && n < 8);
        check("ack_high", {31'd0, ACK_O}, 32'd1);
        rd = DAT_O;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, ACK_O}, 32'd0);
    endtask

    task automatic run_vec(input int i);
        logic [31:0] rd;
        access(tbl[i].we, tbl[i].idx, tbl[i].data, tbl[i].sel, rd);
        if (!tbl[i].we)
            check($sformatf("vec%0d_reg%0d", i, tbl[i].idx), rd, tbl[i].exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int split;
        // Reset defaults, unmapped reads
        R(0, 32'h6); R(2, 32'h0); R(3, 32'h0); R(15, 32'h0);
        // 4:2:0, no rounding; STATUS at +2 shows busy/fill=4, then out_valid
        W(0, 32'h2, 4'h1); group_a();
        R(2, 32'h21); R(2, 32'h02); R(8, 25); R(9, 100);
        R(4, 1); R(5, 2); R(6, 3); R(7, 4); R(2, 32'h0);
        // 4:2:0 with rounding; CBOUT read clears out_valid
        W(0, 32'h6, 4'h1); group_a();
        R(2, 32'h21); R(2, 32'h02); R(8, 26); R(9, 100); R(2, 32'h0);
        // 4:2:2 with rounding at the top of range
        W(0, 32'h5, 4'h1); W(1, 32'h00FF07); W(1, 32'h01FE08);
        R(2, 32'h11); R(2, 32'h02); R(8, 255); R(9, 1); R(4, 7); R(5, 8); R(6, 0);
        // 4:4:4 bypass
        W(0, 32'h4, 4'h1); W(1, 32'h332211);
        R(2, 32'h09); R(2, 32'h02); R(8, 32'h22); R(9, 32'h33); R(4, 32'h11); R(5, 0);
        // MODE=3 stored as 2; CLR reads back 0
        W(0, 32'h3, 4'h1); R(0, 32'h2); W(0, 32'hE, 4'h1); R(0, 32'h6);
        // Overflow: second group's completing write dropped while out_valid=1
        group_a(); R(2, 32'h21); R(2, 32'h02);
        W(1, 32'h32C809); W(1, 32'h32C80A); W(1, 32'h32C80B); W(1, 32'h32C80C);
        R(2, 32'h1F); R(8, 26); R(4, 1);
        W(2, 32'h4, 4'h1); R(2, 32'h1B); R(9, 100);
        W(1, 32'h32C80C); R(2, 32'h21); R(2, 32'h02); R(8, 200); R(7, 12);
        // Partial group before the reset
        W(1, 32'h640A01); W(1, 32'h641402); R(2, 32'h13);
        split = tbl.size();
        // After reset: everything cleared, SEL!=F PIX ignored, partial group gone
        R(2, 32'h0); R(0, 32'h6); R(8, 0); R(4, 0);
        W(1, 32'h640A01, 4'h1); R(2, 32'h0);
        group_a(); R(2, 32'h21); R(2, 32'h02); R(8, 26); R(9, 100);

        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = '0; DAT_I = '0; SEL_I = '0;
        repeat (3) @(negedge clk);
        RST_I = 1'b0;

        for (int i = 0; i < split; i++)
            run_vec(i);

        // Asynchronous reset asserted between edges while a read ACK is high
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = {26'd0, 4'd8, 2'b00}; SEL_I = 4'hF;
        @(posedge clk); #1;
        check("pre_reset_ack", {31'd0, ACK_O}, 32'd1);
        check("pre_reset_crout", DAT_O, 32'd200);
        #2 RST_I = 1'b1;
        #1;
        check("async_reset_ack", {31'd0, ACK_O}, 32'd0);
        check("async_reset_dat", DAT_O, 32'd0);
        CYC_I = 1'b0; STB_I = 1'b0;
        @(negedge clk);
        RST_I = 1'b0;

        for (int i = split; i < tbl.size(); i++)
            run_vec(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
